// File: rtl/cam_pkg.sv
// Shared types, frame geometry and pixel packing for the camera capture sequencer.
package cam_pkg;

    localparam int unsigned H_PIX = 160;
    localparam int unsigned V_PIX = 120;
    localparam int unsigned FRAME = H_PIX * V_PIX;
    localparam int unsigned AW    = 15;
    localparam int unsigned DW    = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cam_state_e;

    // RGB565 byte pair (high byte first) reduced to RGB444 by keeping the top bits of each channel
    function automatic logic [DW-1:0] rgb565_to_444(input logic [7:0] b0, input logic [7:0] b1);
        return {b0[7:4], b0[2:0], b1[7], b1[4:1]};
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchronizer for a bundle of async inputs, with edge detect on the top bits.
module cam_sync_edge #(
    parameter int unsigned W  = 11,
    parameter int unsigned RW = 2,
    parameter int unsigned FW = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     din_i,
    output logic [W-RW-1:0]  sync_o,
    output logic [RW-1:0]    rise_o_c,
    output logic [FW-1:0]    fall_o_c
);

    logic [W-1:0]  meta_q;
    logic [W-1:0]  sync_q;
    logic [RW-1:0] dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            dly_q  <= '0;
        end else begin
            meta_q <= din_i;
            sync_q <= meta_q;
            dly_q  <= sync_q[W-1 -: RW];
        end
    end

    // Edge-detected bits are the MSBs; falls are only formed on the topmost FW of them
    assign sync_o   = sync_q[W-RW-1:0];
    assign rise_o_c = sync_q[W-1 -: RW] & ~dly_q;
    assign fall_o_c = ~sync_q[W-1 -: FW] & dly_q[RW-1 -: FW];

endmodule

// File: rtl/cam_capture_ctrl.sv
// Frame-capture sequencer: conditions OV7670 timing, packs byte pairs to RGB444
// and writes them to sequential frame-buffer addresses under start/abort control.
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = FRAME
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          CAM_PCLK,
    input  logic          CAM_HREF,
    input  logic          CAM_VSYNC,
    input  logic [7:0]    CAM_px_data,
    input  logic          start,
    input  logic          continuous,
    input  logic          abort,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic [DW-1:0] DP_RAM_data_in,
    output logic          DP_RAM_regW,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic [7:0]    frame_cnt
);

    localparam int unsigned SW = 11;
    localparam logic [AW-1:0] FRAME_A = AW'(FRAME_WORDS);

    logic [8:0]    sync_lo;
    logic [1:0]    rise;
    logic [0:0]    fall;
    logic          s_href;
    logic [7:0]    s_data;
    logic          pclk_rise;
    logic          vs_rise;
    logic          vs_fall;

    cam_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          regw_q, regw_d;
    logic [7:0]    b0_q, b0_d;
    logic          phase_q, phase_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // VSYNC and PCLK sit on top so they get edge detect; HREF/data share the same depth
    cam_sync_edge #(.W(SW), .RW(2), .FW(1)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .din_i    ({CAM_VSYNC, CAM_PCLK, CAM_HREF, CAM_px_data}),
        .sync_o   (sync_lo),
        .rise_o_c (rise),
        .fall_o_c (fall)
    );

    assign s_href    = sync_lo[8];
    assign s_data    = sync_lo[7:0];
    assign vs_rise   = rise[1];
    assign pclk_rise = rise[0];
    assign vs_fall   = fall[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)   state_d = ARMED;
            ARMED:   if (vs_fall) state_d = CAPTURE;
            CAPTURE: if (vs_rise) state_d = DONE;
            DONE:    state_d = continuous ? ARMED : IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        regw_d  = 1'b0;
        b0_d    = b0_q;
        phase_d = phase_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);

        if (regw_q) addr_d = addr_q + AW'(1);
        if (state_d == DONE) cnt_d = cnt_q + 8'd1;

        if (state_q == ARMED && state_d == CAPTURE) begin
            addr_d  = '0;
            phase_d = 1'b0;
            ovf_d   = 1'b0;
        end

        // Packing runs through the vs_rise cycle so a pair completing there is still written
        if (state_q == CAPTURE && !abort) begin
            if (!s_href) begin
                phase_d = 1'b0;
            end else if (pclk_rise) begin
                if (!phase_q) begin
                    b0_d    = s_data;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (addr_q < FRAME_A) begin
                        regw_d = 1'b1;
                        data_d = rgb565_to_444(b0_q, s_data);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            data_q  <= '0;
            regw_q  <= 1'b0;
            b0_q    <= '0;
            phase_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            regw_q  <= regw_d;
            b0_q    <= b0_d;
            phase_q <= phase_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign DP_RAM_addr_in = addr_q;
    assign DP_RAM_data_in = data_q;
    assign DP_RAM_regW    = regw_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign overflow       = ovf_q;
    assign frame_cnt      = cnt_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Randomized camera stimulus against a line/pixel-level model of the capture sequencer.
module tb_cam_capture_ctrl;

    localparam int unsigned H  = 8;
    localparam int unsigned V  = 4;
    localparam int unsigned F  = H * V;

    typedef struct packed {
        logic [14:0] a;
        logic [11:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        CAM_PCLK, CAM_HREF, CAM_VSYNC;
    logic [7:0]  CAM_px_data;
    logic        start, continuous, abort;
    logic [14:0] DP_RAM_addr_in;
    logic [11:0] DP_RAM_data_in;
    logic        DP_RAM_regW, busy, done, overflow;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int errors = 0;

    wr_t        got_q[$];
    wr_t        exp_q[$];
    logic [7:0] pre_q[$];
    int         done_cnt = 0;
    int         exp_done = 0;
    int         dbl = 0;
    int         busy_drop = 0;
    logic       watch_busy = 1'b0;
    logic       prev_w = 1'b0;

    // model state
    bit         cap = 1'b0;
    int         pix = 0;
    logic       exp_ovf = 1'b0;
    int         exp_cnt = 0;

    always #5 clk = ~clk;

    cam_capture_ctrl #(.FRAME_WORDS(F)) dut (
        .clk            (clk),
        .rst            (rst),
        .CAM_PCLK       (CAM_PCLK),
        .CAM_HREF       (CAM_HREF),
        .CAM_VSYNC      (CAM_VSYNC),
        .CAM_px_data    (CAM_px_data),
        .start          (start),
        .continuous     (continuous),
        .abort          (abort),
        .DP_RAM_addr_in (DP_RAM_addr_in),
        .DP_RAM_data_in (DP_RAM_data_in),
        .DP_RAM_regW    (DP_RAM_regW),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
        .frame_cnt      (frame_cnt)
    );

    always @(negedge clk) begin
        if (DP_RAM_regW) got_q.push_back({DP_RAM_addr_in, DP_RAM_data_in});
        if (DP_RAM_regW && prev_w) dbl++;
        prev_w = DP_RAM_regW;
        if (done) done_cnt++;
        if (watch_busy && !busy) busy_drop++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ref_pack(input int b0, input int b1);
        int r, g, b;
        r = b0 / 16;
        g = (b0 % 8) * 2 + b1 / 128;
        b = (b1 / 2) % 16;
        return 12'(r * 256 + g * 16 + b);
    endfunction

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pclk_byte(input logic href, input logic [7:0] b);
        CAM_HREF    = href;
        CAM_px_data = b;
        CAM_PCLK    = 1'b0;
        clk_wait($urandom_range(2, 3));
        CAM_PCLK    = 1'b1;
        clk_wait($urandom_range(2, 3));
    endtask

    task automatic model_pair(input logic [7:0] b0, input logic [7:0] b1);
        if (cap) begin
            if (pix < F) begin
                exp_q.push_back({15'(pix), ref_pack(int'(b0), int'(b1))});
                pix++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic send_bytes(input int len);
        logic [7:0] b0, b;
        b0 = 8'h00;
        for (int i = 0; i < len; i++) begin
            if (pre_q.size() > 0) b = pre_q.pop_front();
            else                  b = 8'($urandom);
            pclk_byte(1'b1, b);
            if (i % 2 == 0) b0 = b;
            else            model_pair(b0, b);
        end
    endtask

    task automatic send_line(input int len);
        send_bytes(len);
        repeat (2) pclk_byte(1'b0, 8'h00);
    endtask

    task automatic vsync_pulse();
        CAM_HREF  = 1'b0;
        CAM_PCLK  = 1'b0;
        CAM_VSYNC = 1'b1;
        clk_wait(6);
        CAM_VSYNC = 1'b0;
        clk_wait(6);
    endtask

    task automatic begin_frame();
        cap     = 1'b1;
        pix     = 0;
        exp_ovf = 1'b0;
    endtask

    task automatic end_frame();
        if (cap) begin
            exp_cnt++;
            exp_done++;
        end
        cap = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        clk_wait(1);
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        int n;
        check({tag, "_nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_wr"}, 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
        check({tag, "_fcnt"}, 32'(frame_cnt), 32'(exp_cnt % 256));
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_regw"}, 32'(DP_RAM_regW), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_addr"}, 32'(DP_RAM_addr_in), 32'd0);
        check({tag, "_data"}, 32'(DP_RAM_data_in), 32'd0);
        check({tag, "_fcnt"}, 32'(frame_cnt), 32'd0);
    endtask

    initial begin
        logic [11:0] d0, d1;
        int nl;
        rst = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0;
        CAM_PCLK = 1'b0; CAM_HREF = 1'b0; CAM_VSYNC = 1'b0; CAM_px_data = 8'h00;
        #1 rst = 1'b1;
        #1;
        check_reset_vals("rst0");
        clk_wait(2);
        rst = 1'b0;
        clk_wait(2);

        // single full frame with directed packing pairs at the head
        pre_q = '{8'hE0, 8'h1F, 8'h07, 8'hE0};
        pulse_start();
        check("armed_busy", 32'(busy), 32'd1);
        vsync_pulse();
        begin_frame();
        for (int l = 0; l < V; l++) send_line(2 * H);
        vsync_pulse();
        end_frame();
        d0 = (got_q.size() > 0) ? got_q[0].d : 12'h000;
        d1 = (got_q.size() > 1) ? got_q[1].d : 12'h000;
        check("pack_e01f", 32'(d0), 32'h0E0F);
        check("pack_07e0", 32'(d1), 32'h00F0);
        check_frame("single");
        check("single_idle", 32'(busy), 32'd0);

        // odd-length lines drop the trailing byte
        pulse_start();
        vsync_pulse();
        begin_frame();
        send_line(2 * H + 1);
        send_line(2 * H);
        for (int l = 0; l < 2; l++) send_line($urandom_range(3, 2 * H + 1));
        vsync_pulse();
        end_frame();
        check_frame("odd");

        // one extra line overruns the buffer
        pulse_start();
        vsync_pulse();
        begin_frame();
        for (int l = 0; l < V + 1; l++) send_line(2 * H);
        vsync_pulse();
        end_frame();
        check_frame("ovf");

        // continuous capture of three frames
        continuous = 1'b1;
        pulse_start();
        vsync_pulse();
        begin_frame();
        check("cont_ovf_clr", 32'(overflow), 32'd0);
        watch_busy = 1'b1;
        for (int f = 0; f < 3; f++) begin
            nl = $urandom_range(1, V);
            for (int l = 0; l < nl; l++) send_line($urandom_range(2, 2 * H));
            vsync_pulse();
            end_frame();
            check_frame("cont");
            begin_frame();
        end
        watch_busy = 1'b0;
        continuous = 1'b0;
        do_abort();
        cap = 1'b0;
        check("cont_abort_idle", 32'(busy), 32'd0);
        check("cont_busy_held", 32'(busy_drop), 32'd0);

        // abort in the middle of a line
        pulse_start();
        vsync_pulse();
        begin_frame();
        send_line(2 * H);
        send_line(2 * H);
        send_bytes(6);
        clk_wait(2);
        do_abort();
        cap = 1'b0;
        check("abort_idle", 32'(busy), 32'd0);
        send_bytes(8);
        repeat (2) pclk_byte(1'b0, 8'h00);
        send_line(2 * H);
        vsync_pulse();
        end_frame();
        check_frame("abort");

        // start and abort together leave the block idle
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("sa_idle", 32'(busy), 32'd0);
        vsync_pulse();
        send_line(2 * H);
        vsync_pulse();
        check_frame("sa");

        // asynchronous reset in the middle of capture
        pulse_start();
        vsync_pulse();
        begin_frame();
        send_line(2 * H);
        send_bytes(5);
        rst = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        clk_wait(2);
        rst = 1'b0;
        cap = 1'b0;
        exp_cnt = 0;
        got_q.delete();
        exp_q.delete();
        clk_wait(4);
        check("post_rst_fcnt", 32'(frame_cnt), 32'd0);
        check("strobe_width", 32'(dbl), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
